// File: rtl/axi4lite_master_if.sv
// rtl/axi4lite_master_if.sv - command, response and AXI4-Lite channel bundle for axi4lite_master
interface axi4lite_master_if #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
);
  // command port
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [addrWidth-1:0]   cmd_addr;
  logic [dataWidth-1:0]   cmd_wdata;
  logic [dataWidth/8-1:0] cmd_wstrb;
  logic [2:0]             cmd_prot;
  // response port
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [1:0]             rsp_resp;
  logic [dataWidth-1:0]   rsp_rdata;
  // AXI4-Lite AW
  logic                   awvalid;
  logic                   awready;
  logic [addrWidth-1:0]   awaddr;
  logic [2:0]             awprot;
  // AXI4-Lite W
  logic                   wvalid;
  logic                   wready;
  logic [dataWidth-1:0]   wdata;
  logic [dataWidth/8-1:0] wstrb;
  // AXI4-Lite B
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;
  // AXI4-Lite AR
  logic                   arvalid;
  logic                   arready;
  logic [addrWidth-1:0]   araddr;
  logic [2:0]             arprot;
  // AXI4-Lite R
  logic                   rvalid;
  logic                   rready;
  logic [dataWidth-1:0]   rdata;
  logic [1:0]             rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot, rsp_ready,
           awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata,
           awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_prot, rsp_ready,
           awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_rdata,
           awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready
  );
endinterface

// File: rtl/axi4lite_master.sv
// rtl/axi4lite_master.sv - single-outstanding AXI4-Lite initiator; optional AXIL_MST_ALIGN_CHECK_EN rejects misaligned commands
module axi4lite_master #(
  parameter int addrWidth = 32,
  parameter int dataWidth = 32
) (
  input logic                 clk,
  input logic                 rst,
  axi4lite_master_if.master   bus
);

  if (addrWidth < 1 || (dataWidth != 32 && dataWidth != 64)) begin : gBadParams
    $error("axi4lite_master: unsupported addrWidth/dataWidth");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } stateT;

  stateT state;
  logic  awDone;
  logic  wDone;
  logic  awFire;
  logic  wFire;
  logic  misaligned;

  assign awFire = bus.awvalid && bus.awready;
  assign wFire  = bus.wvalid && bus.wready;

`ifdef AXIL_MST_ALIGN_CHECK_EN
  localparam int lsbWidth = $clog2(dataWidth / 8);
  assign misaligned = |bus.cmd_addr[lsbWidth-1:0];
`else
  assign misaligned = 1'b0;
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      awDone        <= 1'b0;
      wDone         <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_write <= 1'b0;
      bus.rsp_resp  <= 2'b00;
      bus.rsp_rdata <= '0;
      bus.awvalid   <= 1'b0;
      bus.awaddr    <= '0;
      bus.awprot    <= 3'b000;
      bus.wvalid    <= 1'b0;
      bus.wdata     <= '0;
      bus.wstrb     <= '0;
      bus.bready    <= 1'b0;
      bus.arvalid   <= 1'b0;
      bus.araddr    <= '0;
      bus.arprot    <= 3'b000;
      bus.rready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            if (misaligned) begin
              // Misaligned command: answer SLVERR without touching the bus.
              bus.rsp_valid <= 1'b1;
              bus.rsp_write <= bus.cmd_write;
              bus.rsp_resp  <= 2'b10;
              bus.rsp_rdata <= '0;
              state         <= RSP;
            end else if (bus.cmd_write) begin
              bus.awvalid <= 1'b1;
              bus.awaddr  <= bus.cmd_addr;
              bus.awprot  <= bus.cmd_prot;
              bus.wvalid  <= 1'b1;
              bus.wdata   <= bus.cmd_wdata;
              bus.wstrb   <= bus.cmd_wstrb;
              state       <= WR_REQ;
            end else begin
              bus.arvalid <= 1'b1;
              bus.araddr  <= bus.cmd_addr;
              bus.arprot  <= bus.cmd_prot;
              state       <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W complete independently, in either order or together.
          if (awFire) begin
            bus.awvalid <= 1'b0;
            awDone      <= 1'b1;
          end
          if (wFire) begin
            bus.wvalid <= 1'b0;
            wDone      <= 1'b1;
          end
          if ((awDone || awFire) && (wDone || wFire)) begin
            awDone     <= 1'b0;
            wDone      <= 1'b0;
            bus.bready <= 1'b1;
            state      <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bus.bvalid) begin
            bus.bready    <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_write <= 1'b1;
            bus.rsp_resp  <= bus.bresp;
            bus.rsp_rdata <= '0;
            state         <= RSP;
          end
        end

        RD_REQ: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            state       <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (bus.rvalid) begin
            bus.rready    <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_write <= 1'b0;
            bus.rsp_resp  <= bus.rresp;
            bus.rsp_rdata <= bus.rdata;
            state         <= RSP;
          end
        end

        RSP: begin
          // Hold the response until consumed, then return every field to 0.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_resp  <= 2'b00;
            bus.rsp_rdata <= '0;
            bus.awaddr    <= '0;
            bus.awprot    <= 3'b000;
            bus.wdata     <= '0;
            bus.wstrb     <= '0;
            bus.araddr    <= '0;
            bus.arprot    <= 3'b000;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master.sv
// tb/tb_axi4lite_master.sv - scoreboard bench for axi4lite_master
module tb_axi4lite_master;

  logic clk;
  logic rst;

  axi4lite_master_if #(.addrWidth(32), .dataWidth(32)) bus ();

  axi4lite_master #(.addrWidth(32), .dataWidth(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        w;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } expT;

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input logic doPush,
                       input logic [1:0] eResp, input logic [31:0] eData);
    expT e;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    bus.cmd_prot  = p;
    if (doPush) begin
      e.w     = w;
      e.resp  = eResp;
      e.rdata = eData;
      expQ.push_back(e);
    end
  endtask

  // Monitor: every response handshake is compared against the oldest expectation.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (expQ.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = expQ.pop_front();
          chk("rsp_write", bus.rsp_write, e.w);
          chk("rsp_resp",  bus.rsp_resp,  e.resp);
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end
    end
  end

  // Directed stimulus with cycle-exact checks.
  initial begin
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
    bus.cmd_wstrb = 0; bus.cmd_prot = 0; bus.rsp_ready = 1;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    step();
    step();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_outputs", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, bus.rsp_valid}, 0);
    chk("rst_payload", {bus.awaddr, bus.wdata, bus.araddr, bus.rsp_rdata}, 0);
    rst = 1'b0;
    step();
    chk("release_cmd_ready", bus.cmd_ready, 1);

    // Write, slave always ready
    bus.awready = 1; bus.wready = 1; bus.bvalid = 1; bus.bresp = 2'b00;
    issue(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd0, 1, 2'b00, 32'h0);
    step();
    bus.cmd_valid = 0;
    chk("w1_valids", {bus.awvalid, bus.wvalid}, 2'b11);
    chk("w1_awaddr", bus.awaddr, 32'h10);
    chk("w1_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("w1_wstrb", bus.wstrb, 4'hF);
    chk("w1_cmd_ready", bus.cmd_ready, 0);
    step();
    chk("w1_bready", bus.bready, 1);
    chk("w1_valids_done", {bus.awvalid, bus.wvalid}, 2'b00);
    step();
    chk("w1_rsp_valid", bus.rsp_valid, 1);
    step();
    bus.bvalid = 0;
    chk("w1_idle", {bus.cmd_ready, bus.rsp_valid}, 2'b10);

    // Write, W handshake first, AW at cycle 4
    bus.awready = 0; bus.wready = 1; bus.bvalid = 1; bus.bresp = 2'b01;
    issue(1, 32'h20, 32'h1122_3344, 4'h3, 3'd2, 1, 2'b01, 32'h0);
    step();
    bus.cmd_valid = 0;
    chk("w2_c1_valids", {bus.awvalid, bus.wvalid}, 2'b11);
    chk("w2_c1_awprot", bus.awprot, 3'd2);
    step();
    chk("w2_c2_valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    step();
    chk("w2_c3_valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    step();
    chk("w2_c4_valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    chk("w2_c4_awaddr", bus.awaddr, 32'h20);
    bus.awready = 1;
    step();
    bus.awready = 0;
    chk("w2_c5_bready", {bus.awvalid, bus.bready}, 2'b01);
    step();
    chk("w2_rsp_valid", bus.rsp_valid, 1);
    step();
    bus.bvalid = 0; bus.wready = 0;

    // Read with AR stall, SLVERR response
    bus.arready = 0;
    issue(0, 32'h24, 32'h0, 4'h0, 3'd5, 1, 2'b10, 32'h1234_5678);
    step();
    bus.cmd_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      chk("r1_stall_arvalid", bus.arvalid, 1);
      chk("r1_stall_araddr", bus.araddr, 32'h24);
      step();
    end
    chk("r1_c4_araddr", {bus.araddr, bus.arprot}, {32'h24, 3'd5});
    bus.arready = 1;
    step();
    bus.arready = 0;
    chk("r1_c5_rready", {bus.arvalid, bus.rready}, 2'b01);
    bus.rvalid = 1; bus.rdata = 32'h1234_5678; bus.rresp = 2'b10;
    step();
    bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    chk("r1_rsp_valid", {bus.rsp_valid, bus.rready}, 2'b10);
    step();
    chk("r1_idle", bus.cmd_ready, 1);

    // Response backpressure, next command waiting
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hCAFE_0001; bus.rresp = 2'b00;
    bus.rsp_ready = 0;
    issue(0, 32'h8, 32'h0, 4'h0, 3'd0, 1, 2'b00, 32'hCAFE_0001);
    step();
    bus.awready = 1; bus.wready = 1;
    issue(1, 32'h30, 32'h55, 4'hF, 3'd0, 1, 2'b00, 32'h0);
    chk("bp_arvalid", bus.arvalid, 1);
    step();
    chk("bp_rready", bus.rready, 1);
    step();
    bus.rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", {bus.rsp_valid, bus.cmd_ready}, 2'b10);
      chk("bp_hold_rdata", {bus.rsp_rdata, bus.rsp_resp, bus.rsp_write}, {32'hCAFE_0001, 2'b00, 1'b0});
      step();
    end
    bus.rsp_ready = 1;
    step();
    chk("bp_next_accept", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    bus.bvalid = 1; bus.bresp = 2'b00;
    step();
    bus.cmd_valid = 0;
    chk("bp_next_awvalid", {bus.awvalid, bus.awaddr}, {1'b1, 32'h30});
    step();
    chk("bp_next_bready", bus.bready, 1);
    step();
    chk("bp_next_rsp", bus.rsp_valid, 1);
    step();
    bus.bvalid = 0; bus.awready = 0; bus.wready = 0; bus.arready = 0;

    // Reset while in WR_REQ
    issue(1, 32'h40, 32'h77, 4'hF, 3'd1, 0, 2'b00, 32'h0);
    step();
    bus.cmd_valid = 0;
    chk("rr_pre_awvalid", bus.awvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_async_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.cmd_ready, bus.rsp_valid}, 0);
    chk("rr_async_payload", {bus.awaddr, bus.wdata, bus.wstrb, bus.awprot}, 0);
    step();
    rst = 1'b0;
    step();
    chk("rr_release", {bus.cmd_ready, bus.awvalid}, 2'b10);
    bus.awready = 1; bus.wready = 1; bus.bvalid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("rr_no_rsp", {bus.rsp_valid, bus.awvalid, bus.bready}, 0);
      step();
    end
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0;

    // Misaligned read
`ifdef AXIL_MST_ALIGN_CHECK_EN
    issue(0, 32'h2, 32'h0, 4'h0, 3'd0, 1, 2'b10, 32'h0);
    step();
    bus.cmd_valid = 0;
    chk("al_arvalid", bus.arvalid, 0);
    chk("al_rsp", {bus.rsp_valid, bus.rsp_resp}, {1'b1, 2'b10});
    step();
    chk("al_idle", {bus.cmd_ready, bus.arvalid}, 2'b10);
`else
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hA5; bus.rresp = 2'b00;
    issue(0, 32'h2, 32'h0, 4'h0, 3'd0, 1, 2'b00, 32'hA5);
    step();
    bus.cmd_valid = 0;
    chk("al_arvalid", {bus.arvalid, bus.araddr}, {1'b1, 32'h2});
    step();
    chk("al_rready", bus.rready, 1);
    step();
    chk("al_rsp", bus.rsp_valid, 1);
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0;
    step();
`endif

    step();
    step();
    chk("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4lite_master.md
# axi4lite_master

Single-outstanding AXI4-Lite initiator that converts a simple valid/ready command port into AXI4-Lite read and write transactions. It is the master-side counterpart to the AXI4-Lite slave front end of the APB bridge. Benches and on-chip controllers use it to drive the bridge's slave port. It issues exactly one transaction at a time and returns the slave's response and read data on a response port.

## Interface
- `addrWidth`, 32, width of the address on the command port and on AW/AR.
- `dataWidth`, 32, width of the data on the command port and on W/R; must be 32 or 64; `wstrb` width is `dataWidth/8`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  addrWidth  transaction address.
- `cmd_wdata`  in  dataWidth  write data.
- `cmd_wstrb`  in  dataWidth/8  write strobes.
- `cmd_prot`  in  3  value driven on awprot/arprot.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_resp`  out  2  BRESP or RRESP.
- `rsp_rdata`  out  dataWidth  RDATA; 0 for writes.
- AXI4-Lite master channels, standard directions:
  - AW: `awvalid`, `awready`, `awaddr`, `awprot`.
  - W: `wvalid`, `wready`, `wdata`, `wstrb`.
  - B: `bvalid`, `bready`, `bresp[1:0]`.
  - AR: `arvalid`, `arready`, `araddr`, `arprot`.
  - R: `rvalid`, `rready`, `rdata`, `rresp[1:0]`.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - `cmd_ready`=1; all other outputs are held at 0.
  - On `cmd_valid`, the command fields are registered.
  - Write commands go to WR_REQ; read commands go to RD_REQ.
- WR_REQ:
  - `awvalid` and `wvalid` assert together, driven from the registered fields.
  - Each channel deasserts its valid independently on its own handshake. Separate `aw_done` and `w_done` flags track the handshakes, and either order is allowed.
  - When both are done, including the case where both complete in the same cycle, go to WR_RESP.
- WR_RESP:
  - `bready`=1.
  - On `bvalid`, capture `bresp`, set `rsp_write`=1 and `rsp_rdata`=0, then go to RSP.
- RD_REQ:
  - `arvalid`=1.
  - On `arready`, go to RD_RESP.
- RD_RESP:
  - `rready`=1.
  - On `rvalid`, capture `rdata` and `rresp`, set `rsp_write`=0, then go to RSP.
- RSP:
  - `rsp_valid`=1, and the response fields are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- Once a valid is raised on any AXI channel, it is never dropped before its handshake, and the payload on that channel never changes while valid is high.
- `bvalid` and `rvalid` are ignored outside their wait states.
- Reset asserted mid-transaction:
  - All state is cleared immediately (asynchronous) and the FSM returns to IDLE.
  - Every output returns to its reset value, and no response is produced for the aborted command.

## Timing
- Reset values:
  - `cmd_ready`=0 while `rst` is high, and 1 in the first cycle after release.
  - All AXI valid/ready outputs, `rsp_valid`, `rsp_write`, `rsp_resp`, `rsp_rdata`, `awaddr`, `araddr`, `wdata`, `wstrb`, `awprot` and `arprot` reset to 0.
- Every output comes from a register or from a decode of the registered state. There is no combinational path from any input to any output.
- Minimum write latency, with `cmd` accepted at cycle 0:
  - `awvalid`/`wvalid` are high at cycle 1.
  - With both readies high, `bready`=1 at cycle 2.
  - With `bvalid` at cycle 2, `rsp_valid`=1 at cycle 3.
- Minimum read latency, with `cmd` accepted at cycle 0: `arvalid` at cycle 1, `rready` at cycle 2, `rsp_valid` at cycle 3.
- Back-to-back throughput: the next command is accepted one cycle after `rsp_ready`. The peak rate is one transaction per 4 cycles.

## Configuration
- Macro: `AXIL_MST_ALIGN_CHECK_EN`.
- When defined:
  - A command whose `cmd_addr[log2(dataWidth/8)-1:0]` is non-zero is accepted but issues no AXI traffic.
  - The FSM goes IDLE→RSP directly, with `rsp_resp`=2'b10 (SLVERR), `rsp_rdata`=0, and `rsp_write` set equal to `cmd_write`.
  - `rsp_valid` is high in the cycle after acceptance.
- When undefined: no address check; every command is issued on the bus unchanged.

## Test plan
- Write, slave always ready: `cmd_write`=1, `cmd_addr`=0x0000_0010, `cmd_wdata`=0xDEAD_BEEF, `cmd_wstrb`=0xF; the slave returns `bresp`=0 at the first `bready`. Required response: `awaddr`=0x10 and `wdata`=0xDEAD_BEEF at cycle 1, and `rsp_valid` at cycle 3 with `rsp_resp`=0 and `rsp_write`=1.
- Write, handshakes in skewed order: `wready` is high at cycle 1 and `awready` only at cycle 4. Required response: `wvalid` drops after cycle 1, `awvalid` stays high through cycle 4, and `bready` first goes high at cycle 5.
- Read with stalls: `cmd_addr`=0x0000_0024, `arready` delayed 3 cycles, then `rvalid` with `rdata`=0x1234_5678 and `rresp`=2'b10. Required response: `araddr` is stable for the whole stall, and the response shows `rsp_rdata`=0x1234_5678, `rsp_resp`=2'b10 and `rsp_write`=0.
- Response backpressure: `rsp_ready` held low for 5 cycles. Required response: `rsp_*` are stable, `cmd_ready` stays 0, and the next command is accepted one cycle after `rsp_ready`.
- Reset mid-transaction: `rst` pulses high while in WR_REQ with `awvalid`=1. Required response: all outputs are 0 immediately, `cmd_ready`=1 after release, and no `rsp_valid` ever appears for the aborted command.
- With `AXIL_MST_ALIGN_CHECK_EN` defined: a read at `cmd_addr`=0x0000_0002. Required response: `arvalid` never asserts, and `rsp_valid` is high one cycle after acceptance with `rsp_resp`=2'b10.
